// File: rtl/psum_accum_wb.sv
// rtl/psum_accum_wb.sv - accumulates OFIFO partial-sum rows over all kij positions, then drains with optional ReLU
module psum_accum_wb #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int DEPTH   = 16,
  parameter int KIJ     = 9,
  parameter int ADDR_BW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     relu_en,
  input  logic                     ofifo_valid,
  input  logic [psum_bw*col-1:0]   ofifo_data,
  output logic                     ofifo_rd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_BW-1:0]       out_addr,
  output logic [psum_bw*col-1:0]   out_data,
  output logic                     busy,
  output logic                     done
);

  localparam int KBW = (KIJ > 1) ? $clog2(KIJ) : 1;

  typedef logic [col-1:0][psum_bw-1:0] row_t;
  typedef enum logic [1:0] {IDLE, ACC, DRAIN, DONE} state_t;

  state_t             state, state_n;
  logic [ADDR_BW-1:0] nij, drain_cnt;
  logic [KBW-1:0]     kij;
  logic               relu_r;
  row_t               buf_mem [DEPTH];
  row_t               din, acc_row, rd_row, drain_row;
  logic               last_nij, last_kij, last_drain;

  assign din        = ofifo_data;
  assign last_nij   = (nij == ADDR_BW'(DEPTH - 1));
  assign last_kij   = (kij == KBW'(KIJ - 1));
  assign last_drain = (drain_cnt == ADDR_BW'(DEPTH - 1));

  assign ofifo_rd  = (state == ACC) && ofifo_valid;
  assign out_valid = (state == DRAIN);
  assign out_addr  = drain_cnt;
  assign out_data  = drain_row;
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = ACC;
      ACC:     if (ofifo_valid && last_nij && last_kij) state_n = DRAIN;
      DRAIN:   if (out_ready && last_drain) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      nij       <= '0;
      kij       <= '0;
      drain_cnt <= '0;
      relu_r    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            relu_r    <= relu_en;
            nij       <= '0;
            kij       <= '0;
            drain_cnt <= '0;
          end
        end
        ACC: begin
          if (ofifo_valid) begin
            if (last_nij) begin
              nij <= '0;
              kij <= last_kij ? '0 : kij + 1'b1;
            end else begin
              nij <= nij + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) drain_cnt <= last_drain ? '0 : drain_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // the first kernel position overwrites, so the buffer never needs clearing
  always_comb begin
    acc_row = '0;
    for (int i = 0; i < col; i++)
      acc_row[i] = (kij == '0) ? din[i] : buf_mem[nij][i] + din[i];
  end

  always_ff @(posedge clk) begin
    if (ofifo_rd) buf_mem[nij] <= acc_row;
  end

  always_comb begin
    rd_row    = buf_mem[drain_cnt];
    drain_row = '0;
    if (state == DRAIN) begin
      for (int i = 0; i < col; i++)
        drain_row[i] = (relu_r && rd_row[i][psum_bw-1]) ? '0 : rd_row[i];
    end
  end

endmodule

// File: tb/tb_psum_accum_wb.sv
// tb/tb_psum_accum_wb.sv - directed self-checking bench for psum_accum_wb across three configurations
module tb_psum_accum_wb;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         relu_en = 1'b0;
  logic         ofifo_valid = 1'b0;
  logic [127:0] ofifo_data = '0;
  logic         out_ready = 1'b1;
  int           sel = 0;

  logic [2:0]   rd_v, ov_v, busy_v, done_v;
  logic [127:0] od_v [3];
  logic [1:0]   oa0, oa2;
  logic [3:0]   oa1;

  logic         m_ofifo_rd, m_out_valid, m_busy, m_done;
  logic [3:0]   m_out_addr;
  logic [127:0] m_out_data;

  int checks = 0;
  int errors = 0;

  logic [127:0] feed [$];
  logic [127:0] dout [16];

  always #5 clk = ~clk;

  psum_accum_wb #(.col(8), .psum_bw(16), .DEPTH(4), .KIJ(1)) u_copy (
    .clk(clk), .reset(reset), .start(start && sel == 0), .relu_en(relu_en),
    .ofifo_valid(ofifo_valid), .ofifo_data(ofifo_data), .ofifo_rd(rd_v[0]),
    .out_valid(ov_v[0]), .out_ready(out_ready), .out_addr(oa0), .out_data(od_v[0]),
    .busy(busy_v[0]), .done(done_v[0]));

  psum_accum_wb #(.col(8), .psum_bw(16), .DEPTH(16), .KIJ(9)) u_full (
    .clk(clk), .reset(reset), .start(start && sel == 1), .relu_en(relu_en),
    .ofifo_valid(ofifo_valid), .ofifo_data(ofifo_data), .ofifo_rd(rd_v[1]),
    .out_valid(ov_v[1]), .out_ready(out_ready), .out_addr(oa1), .out_data(od_v[1]),
    .busy(busy_v[1]), .done(done_v[1]));

  psum_accum_wb #(.col(8), .psum_bw(16), .DEPTH(4), .KIJ(2)) u_two (
    .clk(clk), .reset(reset), .start(start && sel == 2), .relu_en(relu_en),
    .ofifo_valid(ofifo_valid), .ofifo_data(ofifo_data), .ofifo_rd(rd_v[2]),
    .out_valid(ov_v[2]), .out_ready(out_ready), .out_addr(oa2), .out_data(od_v[2]),
    .busy(busy_v[2]), .done(done_v[2]));

  always_comb begin
    m_ofifo_rd  = rd_v[sel];
    m_out_valid = ov_v[sel];
    m_busy      = busy_v[sel];
    m_done      = done_v[sel];
    m_out_data  = od_v[sel];
    case (sel)
      0:       m_out_addr = {2'b00, oa0};
      1:       m_out_addr = oa1;
      default: m_out_addr = {2'b00, oa2};
    endcase
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] lanes(input logic [15:0] v);
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[16*i +: 16] = v;
    return r;
  endfunction

  function automatic logic [127:0] row_for(input int mode, input int n, input int k);
    logic [127:0] r;
    r = '0;
    case (mode)
      0: r = lanes(16'(n + 1));
      1: r = lanes(16'd1);
      2: begin
        if (n == 0) begin
          r[15:0]  = (k == 0) ? 16'hFFFD : 16'hFFFE;
          r[31:16] = (k == 0) ? 16'd3 : 16'd4;
        end else if (n == 1) begin
          r[15:0] = (k == 0) ? 16'h7FFF : 16'h0001;
        end
      end
      3: for (int i = 0; i < 8; i++) r[16*i +: 16] = 16'(n + k + i);
      4: r = lanes(16'd2);
      default: r = lanes(16'd7);
    endcase
    return r;
  endfunction

  task automatic build(input int mode, input int kij, input int depth);
    feed.delete();
    for (int k = 0; k < kij; k++)
      for (int n = 0; n < depth; n++)
        feed.push_back(row_for(mode, n, k));
  endtask

  task automatic run_pass(input int s, input bit relu, input int kij, input int depth,
                          input bit gaps, input int stall_addr, input bit start_in_drain);
    int cyc = 0, pops = 0, dones = 0, exp_addr = 0, stall_cnt = 0;
    bit finished = 0, stalled_prev = 0, did_start = 0;
    logic [3:0]   held_addr = '0;
    logic [127:0] held_data = '0;
    @(negedge clk);
    sel = s; relu_en = relu; start = 1'b1; ofifo_valid = 1'b0; out_ready = 1'b1;
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      start = 1'b0;
      relu_en = 1'b0;
      ofifo_valid = (feed.size() > 0) && (!gaps || $urandom_range(0, 3) != 0);
      ofifo_data  = (feed.size() > 0) ? feed[0] : '0;
      out_ready   = 1'b1;
      if (stall_addr >= 0 && m_out_valid && m_out_addr == 4'(stall_addr) && stall_cnt < 3) begin
        out_ready = 1'b0;
        stall_cnt++;
      end
      if (start_in_drain && m_out_valid && m_out_addr == 4'd2 && !did_start) begin
        start = 1'b1;
        did_start = 1;
      end
      #1;
      if (stalled_prev) begin
        check("held_addr", {124'd0, m_out_addr}, {124'd0, held_addr});
        check("held_data", m_out_data, held_data);
      end
      if (!m_out_valid) check("idle_data_zero", m_out_data, '0);
      if (m_ofifo_rd) begin
        void'(feed.pop_front());
        pops++;
      end
      if (m_out_valid && out_ready) begin
        check("drain_addr", {124'd0, m_out_addr}, 128'(exp_addr));
        if (exp_addr < 16) dout[exp_addr] = m_out_data;
        exp_addr++;
      end
      stalled_prev = m_out_valid && !out_ready;
      held_addr = m_out_addr;
      held_data = m_out_data;
      if (m_done) begin
        dones++;
        finished = 1;
      end
      cyc++;
    end
    if (!finished) check("pass_timeout", 128'd0, 128'd1);
    check("pop_count", 128'(pops), 128'(kij * depth));
    check("drain_count", 128'(exp_addr), 128'(depth));
    check("done_pulses", 128'(dones), 128'd1);
    if (stall_addr >= 0) check("stall_cycles", 128'(stall_cnt), 128'd3);
    @(negedge clk);
    start = 1'b0; ofifo_valid = 1'b0;
    #1;
    check("busy_after_done", {127'd0, m_busy}, 128'd0);
    check("done_after_done", {127'd0, m_done}, 128'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd"},    {127'd0, m_ofifo_rd}, 128'd0);
    check({tag, "_valid"}, {127'd0, m_out_valid}, 128'd0);
    check({tag, "_addr"},  {124'd0, m_out_addr}, 128'd0);
    check({tag, "_data"},  m_out_data, 128'd0);
    check({tag, "_busy"},  {127'd0, m_busy}, 128'd0);
    check({tag, "_done"},  {127'd0, m_done}, 128'd0);
  endtask

  logic [127:0] e;

  initial begin
    ofifo_valid = 1'b1;
    ofifo_data  = lanes(16'h1234);
    repeat (2) @(negedge clk);
    #1;
    sel = 0;
    check_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    ofifo_valid = 1'b0;

    // copy: KIJ=1, DEPTH=4
    build(0, 1, 4);
    run_pass(0, 1'b0, 1, 4, 1'b0, -1, 1'b0);
    for (int n = 0; n < 4; n++) check("copy_row", dout[n], lanes(16'(n + 1)));

    // accumulate ones over 9 kernel positions
    build(1, 9, 16);
    run_pass(1, 1'b0, 9, 16, 1'b0, -1, 1'b0);
    for (int n = 0; n < 16; n++) check("acc_row", dout[n], lanes(16'd9));

    // ReLU on, then off, with signed and wrapping lanes
    build(2, 2, 4);
    run_pass(2, 1'b1, 2, 4, 1'b0, -1, 1'b0);
    e = '0; e[31:16] = 16'h0007;
    check("relu_px0", dout[0], e);
    check("relu_px1_wrap_neg", dout[1], '0);
    build(2, 2, 4);
    run_pass(2, 1'b0, 2, 4, 1'b0, -1, 1'b0);
    e = '0; e[15:0] = 16'hFFFB; e[31:16] = 16'h0007;
    check("norelu_px0", dout[0], e);
    e = '0; e[15:0] = 16'h8000;
    check("wrap_px1", dout[1], e);
    check("zero_px2", dout[2], '0);

    // flow control: random OFIFO gaps, consumer stall at address 5
    build(3, 9, 16);
    run_pass(1, 1'b0, 9, 16, 1'b1, 5, 1'b0);
    for (int n = 0; n < 16; n++) begin
      e = '0;
      for (int i = 0; i < 8; i++) e[16*i +: 16] = 16'(9 * (n + i) + 36);
      check("flow_row", dout[n], e);
    end

    // reset in ACC at kij=4, nij=3
    build(5, 9, 16);
    @(negedge clk);
    sel = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int p = 0; p < 67; p++) begin
      ofifo_valid = 1'b1;
      ofifo_data  = feed.pop_front();
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clk);
    reset = 1'b0;
    ofifo_valid = 1'b0;

    // fresh pass after the aborted one; start pulsed during drain is ignored
    build(4, 9, 16);
    run_pass(1, 1'b0, 9, 16, 1'b0, -1, 1'b1);
    for (int n = 0; n < 16; n++) check("post_reset_row", dout[n], lanes(16'd18));
    repeat (3) @(negedge clk);
    #1;
    check("idle_after_drain_start", {127'd0, m_busy}, 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
